mem_access_ctrl: RTL
====================

# mem_access_ctrl

Initiator side of the byte-wide MOV/MOC memory handshake used by the design's RAM. It sits between the CPU control unit and a byte-addressed memory. It accepts one byte, halfword or word load/store request, splits it into big-endian byte transfers (lowest address carries bits 31:24), and runs a 4-phase handshake per byte. It returns read data, a done pulse and an error flag for misalignment, out-of-range addresses or responder timeout.

## Interface
Parameters:
- ADDR_WIDTH, 9: memory address width (512 bytes).
- TIMEOUT, 16: maximum cycles spent waiting for any single MOC edge.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe, sampled only in IDLE.
- op_write  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- sign_ext  in  1  sign-extend byte/halfword loads.
- addr  in  32  byte address of first byte.
- wdata  in  32  store data, right-aligned.
- busy  out  1  high from the cycle after accepted start through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = request failed.
- rdata  out  32  load result, right-aligned.
- mov  out  1  memory operation valid.
- rw  out  1  1 = read, 0 = write; valid while mov high.
- mar  out  ADDR_WIDTH  byte address of current transfer.
- mdr_out  out  8  write byte.
- mdr_in  in  8  read byte, valid when moc high.
- moc  in  1  memory operation complete.

## Operation
- States: IDLE, CHECK, REQ, RELEASE, DONE.
- IDLE: on start, latch op_write, size, sign_ext, addr and wdata, then go to CHECK. start is ignored in every other state.
- CHECK: error if size=11, if halfword has addr[0]=1, if word has addr[1:0]≠0, or if addr[31:ADDR_WIDTH]≠0. An error goes straight to DONE with err=1 and no memory traffic. Otherwise set n = 1/2/4 bytes and k = 0, then go to REQ.
- REQ: mov=1, mar=addr+k, rw=~op_write.
  - mdr_out = store byte k, where byte 0 is the most significant of the n right-aligned bytes.
  - On sampled moc=1, a load shifts mdr_in into the read shift register, then the block goes to RELEASE.
- RELEASE: mov=0, wait for sampled moc=0. Then, if k=n-1, go to DONE; otherwise k++ and go to REQ.
- Watchdog: the counter clears on entering REQ or RELEASE and increments each waiting cycle. If the awaited moc level is still absent when the count reaches TIMEOUT-1, the block aborts to DONE with err=1, mov=0 and rdata unchanged.
- DONE: done=1 for one cycle, err as determined. On a successful load, rdata takes the shift register, zero- or sign-extended from 8/16 bits per sign_ext. Next state is IDLE.
- rdata holds its value until the next successful load; stores never change it.
- mar, mdr_out and rw hold their last values when mov=0.

## Timing
- Reset (async, immediate): state IDLE; busy, done, err, mov and rw are 0; mar, mdr_out, rdata and all counters are 0. Reset mid-transfer drops mov in the same cycle.
- start sampled at edge 0 → CHECK in cycle 1 (busy=1) → first REQ in cycle 2.
- With a responder that sets moc combinationally equal to mov, each byte takes 2 cycles (REQ, RELEASE):
  - byte access: done in cycle 4.
  - halfword: done in cycle 6.
  - word: done in cycle 10.
- Error detected in CHECK: done/err in cycle 2.
- Timeout: mov stays high for exactly TIMEOUT cycles, then done/err follows on the next cycle.
- start asserted during the DONE cycle is ignored. The earliest acceptance is the IDLE cycle after it.
- moc already high on entering REQ counts as an immediate acknowledge.

## Structure
- Package mem_if_pkg holds the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD), the state enum, and the byte-count function size→n.
- One sub-module, handshake_watchdog: counter with clear, enable and TIMEOUT parameter, outputs expired. The FSM, address/data sequencing and extension logic stay in mem_access_ctrl.

## Test plan
- Word load, memory bytes 0x10..0x13 = 8C,01,00,FF, combinational responder → mar sequence 0x10,0x11,0x12,0x13; rdata=0x8C0100FF, done in cycle 10, err=0.
- Byte load 0x10, sign_ext=1 → rdata=0xFFFFFF8C; same load with sign_ext=0 → 0x0000008C; halfword load 0x12, sign_ext=1 → 0x000000FF.
- Halfword store wdata=0x0000ABCD to 0x20 → mem[0x20]=AB, mem[0x21]=CD, rw=0 on both transfers, rdata unchanged.
- Misaligned word load at 0x22, size=11, and addr=0x200 → each gives done+err in cycle 2, mov never asserted.
- Responder that never raises moc, TIMEOUT=16 → mov high 16 cycles, then done+err; next request completes normally. A responder with 3-cycle latency completes a word without error.
- reset_n pulled low during the third byte of a word load → mov, busy and done go to 0 immediately, rdata=0; after release, a byte load succeeds.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared encodings, FSM states and byte-lane helpers for mem_access_ctrl
package mem_if_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_REQ,
      ST_RELEASE,
      ST_DONE
   } state_t;

   function automatic logic [2:0] byte_count(input logic [1:0] size);
      case (size)
         SIZE_HALF: return 3'd2;
         SIZE_WORD: return 3'd4;
         default:   return 3'd1;
      endcase
   endfunction

   // Transfer k carries the most significant of the n right-aligned bytes first.
   function automatic logic [7:0] store_byte(input logic [31:0] w,
                                             input logic [2:0]  n,
                                             input logic [1:0]  k);
      logic [1:0] idx;
      idx = 2'(n - 3'd1 - {1'b0, k});
      return w[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - byte-wide MOV/MOC memory handshake bus
interface mem_bus_if #(
   parameter int ADDR_WIDTH = 9
);
   logic                  mov;
   logic                  rw;
   logic [ADDR_WIDTH-1:0] mar;
   logic [7:0]            mdr_out;
   logic [7:0]            mdr_in;
   logic                  moc;

   modport master (output mov, rw, mar, mdr_out, input mdr_in, moc);
   modport slave  (input mov, rw, mar, mdr_out, output mdr_in, moc);
endinterface

// File: rtl/mem_access_ctrl_watchdog.sv
// rtl/mem_access_ctrl_watchdog.sv - wait-cycle counter flagging a stalled MOC edge
module handshake_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt;

   assign expired = (cnt == CW'(TIMEOUT - 1));

   // Saturates at the expiry value so the flag cannot wrap back to clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - splits byte/half/word requests into big-endian MOV/MOC byte transfers
module mem_access_ctrl
   import mem_if_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int TIMEOUT    = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        op_write,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   mem_bus_if.master   bus
);

   state_t      state;
   logic        op_write_q;
   logic        sign_ext_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] shreg;
   logic [2:0]  n_q;
   logic [1:0]  k;
   logic [1:0]  k_next;
   logic        last;
   logic        chk_err;
   logic        waiting;
   logic        wd_expired;
   logic [31:0] load_val;

   assign k_next  = k + 2'd1;
   assign last    = ({1'b0, k} == (n_q - 3'd1));
   assign waiting = ((state == ST_REQ) && !bus.moc) || ((state == ST_RELEASE) && bus.moc);

   handshake_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (!waiting),
      .en      (waiting),
      .expired (wd_expired)
   );

   always_comb begin
      chk_err = 1'b0;
      case (size_q)
         SIZE_BYTE: chk_err = 1'b0;
         SIZE_HALF: chk_err = addr_q[0];
         SIZE_WORD: chk_err = |addr_q[1:0];
         default:   chk_err = 1'b1;
      endcase
      if ((addr_q >> ADDR_WIDTH) != 32'd0) begin
         chk_err = 1'b1;
      end
   end

   always_comb begin
      load_val = shreg;
      case (size_q)
         SIZE_BYTE: load_val = sign_ext_q ? {{24{shreg[7]}}, shreg[7:0]}
                                          : {24'd0, shreg[7:0]};
         SIZE_HALF: load_val = sign_ext_q ? {{16{shreg[15]}}, shreg[15:0]}
                                          : {16'd0, shreg[15:0]};
         default:   load_val = shreg;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         rdata       <= '0;
         bus.mov     <= 1'b0;
         bus.rw      <= 1'b0;
         bus.mar     <= '0;
         bus.mdr_out <= '0;
         op_write_q  <= 1'b0;
         sign_ext_q  <= 1'b0;
         size_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         shreg       <= '0;
         n_q         <= '0;
         k           <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_write_q <= op_write;
                  size_q     <= size;
                  sign_ext_q <= sign_ext;
                  addr_q     <= addr;
                  wdata_q    <= wdata;
                  busy       <= 1'b1;
                  err        <= 1'b0;
                  state      <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               n_q   <= byte_count(size_q);
               k     <= 2'd0;
               shreg <= '0;
               if (chk_err) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  bus.mov     <= 1'b1;
                  bus.rw      <= ~op_write_q;
                  bus.mar     <= addr_q[ADDR_WIDTH-1:0];
                  bus.mdr_out <= store_byte(wdata_q, byte_count(size_q), 2'd0);
                  state       <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (bus.moc) begin
                  if (!op_write_q) begin
                     shreg <= {shreg[23:0], bus.mdr_in};
                  end
                  bus.mov <= 1'b0;
                  state   <= ST_RELEASE;
               end else if (wd_expired) begin
                  bus.mov <= 1'b0;
                  err     <= 1'b1;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end
            end
            ST_RELEASE: begin
               if (!bus.moc) begin
                  if (last) begin
                     done <= 1'b1;
                     if (!op_write_q) begin
                        rdata <= load_val;
                     end
                     state <= ST_DONE;
                  end else begin
                     k           <= k_next;
                     bus.mov     <= 1'b1;
                     bus.mar     <= addr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k_next);
                     bus.mdr_out <= store_byte(wdata_q, n_q, k_next);
                     state       <= ST_REQ;
                  end
               end else if (wd_expired) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
